// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and flag bit positions in out_flags.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ADD     = 4'd0;
  localparam alu_op_t ADD_C   = 4'd1;
  localparam alu_op_t SUB     = 4'd2;
  localparam alu_op_t SUB_B   = 4'd3;
  localparam alu_op_t AND     = 4'd4;
  localparam alu_op_t OR      = 4'd5;
  localparam alu_op_t XOR     = 4'd6;
  localparam alu_op_t SHIFT_L = 4'd7;
  localparam alu_op_t SHIFT_R = 4'd8;
  localparam alu_op_t ROT_L   = 4'd9;
  localparam alu_op_t ROT_R   = 4'd10;
  localparam alu_op_t G_T     = 4'd11;
  localparam alu_op_t L_T     = 4'd12;
  localparam alu_op_t NOT_A   = 4'd13;
  localparam alu_op_t NOT_B   = 4'd14;
  localparam alu_op_t XOR_P   = 4'd15;

  localparam int unsigned FLG_COUT    = 4;
  localparam int unsigned FLG_BORROW  = 3;
  localparam int unsigned FLG_ZERO    = 2;
  localparam int unsigned FLG_PARITY  = 1;
  localparam int unsigned FLG_INVALID = 0;
  localparam int unsigned FlagW       = 5;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; pointers wrap modulo Depth.
module alu_cmd_fifo #(
  parameter int unsigned Width = 21,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointer and count next-state; count alone tells full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates their use.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/alu_issue_queue.sv
// Command queue in front of a combinational ALU plus a valid/ready result register behind it.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0]              in_a,
  input  logic [N-1:0]              in_b,
  input  logic                      in_c_in,
  input  logic [3:0]                in_control,
  output logic [N-1:0]              alu_a,
  output logic [N-1:0]              alu_b,
  output logic                      alu_c_in,
  output logic [3:0]                alu_control,
  input  logic [N-1:0]              alu_result,
  input  logic                      alu_c_out,
  input  logic                      alu_borrow,
  input  logic                      alu_zero,
  input  logic                      alu_parity,
  input  logic                      alu_invalid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0]              out_result,
  output logic [4:0]                out_flags,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [CNT_W-1:0]          invalid_count
);

  localparam int unsigned CmdW = N + N + 1 + 4;

  logic [CmdW-1:0] wdata, head;
  logic            push, pop, fifo_full, fifo_empty;

  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_result_q, out_result_d;
  logic [4:0]       out_flags_q, out_flags_d;
  logic [CNT_W-1:0] invalid_count_q, invalid_count_d;

  // Entry layout: {control, c_in, a, b}.
  assign wdata = {in_control, in_c_in, in_a, in_b};

  // in_ready ignores a same-cycle pop, so a full queue always stalls input.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = !fifo_empty && (!out_valid_q || out_ready);

  alu_cmd_fifo #(
    .Width (CmdW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Present the head command to the ALU; an empty queue drives all zeros.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_c_in    = 1'b0;
    alu_control = '0;
    if (!fifo_empty) begin
      alu_control = head[CmdW-1 -: 4];
      alu_c_in    = head[2*N];
      alu_a       = head[2*N-1 -: N];
      alu_b       = head[N-1:0];
    end
  end

  // Result register next-state: capture on pop, clear valid on a bare output handshake.
  always_comb begin
    out_valid_d     = out_valid_q;
    out_result_d    = out_result_q;
    out_flags_d     = out_flags_q;
    invalid_count_d = invalid_count_q;
    if (pop) begin
      out_valid_d              = 1'b1;
      out_result_d             = alu_result;
      out_flags_d[FLG_COUT]    = alu_c_out;
      out_flags_d[FLG_BORROW]  = alu_borrow;
      out_flags_d[FLG_ZERO]    = alu_zero;
      out_flags_d[FLG_PARITY]  = alu_parity;
      out_flags_d[FLG_INVALID] = alu_invalid;
      if (alu_invalid && (invalid_count_q != {CNT_W{1'b1}})) begin
        invalid_count_d = invalid_count_q + 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage state; reset discards any pending result without a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      out_result_q    <= '0;
      out_flags_q     <= '0;
      invalid_count_q <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_result_q    <= out_result_d;
      out_flags_q     <= out_flags_d;
      invalid_count_q <= invalid_count_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_flags     = out_flags_q;
  assign invalid_count = invalid_count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue with a behavioural ALU stub and a queue-based model.
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] r;
    logic [4:0] f;
  } res_t;

  typedef struct packed {
    logic [3:0] ctl;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_c_in, out_ready, force_inv;
  logic [7:0] in_a, in_b;
  logic [3:0] in_control;
  logic [7:0] alu_a, alu_b, alu_result, out_result;
  logic       alu_c_in, alu_c_out, alu_borrow, alu_zero, alu_parity, alu_invalid, out_valid;
  logic [3:0] alu_control;
  logic [4:0] out_flags;
  logic [2:0] fifo_count;
  logic [7:0] invalid_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pending commands in order plus the held result.
  cmd_t       q[$];
  logic       m_ov;
  logic [7:0] m_res;
  logic [4:0] m_flg;
  int         m_icnt;

  always #5 clk = ~clk;

  // Behavioural ALU: parity flag is produced only by XOR_P; invalid is bench-forced.
  function automatic res_t alu_fn(input logic [3:0] ctl, input logic [7:0] a,
                                  input logic [7:0] b, input logic ci, input logic inv);
    res_t o;
    logic [8:0] w;
    logic co, bo, par;
    w = '0; co = 1'b0; bo = 1'b0; par = 1'b0;
    case (ctl)
      ADD:     begin w = {1'b0, a} + {1'b0, b}; co = w[8]; end
      ADD_C:   begin w = {1'b0, a} + {1'b0, b} + {8'd0, ci}; co = w[8]; end
      SUB:     begin w = {1'b0, a} - {1'b0, b}; bo = w[8]; end
      SUB_B:   begin w = {1'b0, a} - {1'b0, b} - {8'd0, ci}; bo = w[8]; end
      AND:     w = {1'b0, a & b};
      OR:      w = {1'b0, a | b};
      XOR:     w = {1'b0, a ^ b};
      SHIFT_L: begin w = {a, 1'b0}; co = a[7]; end
      SHIFT_R: begin w = {2'b0, a[7:1]}; co = a[0]; end
      ROT_L:   w = {1'b0, a[6:0], a[7]};
      ROT_R:   w = {1'b0, a[0], a[7:1]};
      G_T:     w = {8'd0, a > b};
      L_T:     w = {8'd0, a < b};
      NOT_A:   w = {1'b0, ~a};
      NOT_B:   w = {1'b0, ~b};
      default: begin w = {1'b0, a ^ b}; par = ^(a ^ b); end
    endcase
    o.r = w[7:0];
    o.f = {co, bo, (w[7:0] == 8'd0), par, inv};
    return o;
  endfunction

  res_t stub;
  always_comb begin
    stub = alu_fn(alu_control, alu_a, alu_b, alu_c_in, force_inv);
    alu_result = stub.r;
    {alu_c_out, alu_borrow, alu_zero, alu_parity, alu_invalid} = stub.f;
  end

  alu_issue_queue #(.N(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_c_in       (in_c_in),
    .in_control    (in_control),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_c_in      (alu_c_in),
    .alu_control   (alu_control),
    .alu_result    (alu_result),
    .alu_c_out     (alu_c_out),
    .alu_borrow    (alu_borrow),
    .alu_zero      (alu_zero),
    .alu_parity    (alu_parity),
    .alu_invalid   (alu_invalid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_flags     (out_flags),
    .fifo_count    (fifo_count),
    .invalid_count (invalid_count)
  );

  task automatic drive(input logic v, input logic [3:0] ctl, input logic [7:0] a,
                       input logic [7:0] b, input logic ci);
    in_valid = v; in_control = ctl; in_a = a; in_b = b; in_c_in = ci;
  endtask

  // Advance one clock edge, updating the model from the inputs present at that edge.
  task automatic tick();
    bit   do_push, do_pop;
    res_t r;
    cmd_t c;
    do_push = in_valid && (q.size() != DEPTH);
    do_pop  = (q.size() != 0) && (!m_ov || out_ready);
    if (do_pop) begin
      r = alu_fn(q[0].ctl, q[0].a, q[0].b, q[0].ci, force_inv);
      m_res = r.r; m_flg = r.f; m_ov = 1'b1;
      if (r.f[0] && m_icnt < 255) m_icnt++;
      void'(q.pop_front());
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    if (do_push) begin
      c.ctl = in_control; c.a = in_a; c.b = in_b; c.ci = in_c_in;
      q.push_back(c);
    end
    if (rst) begin
      q.delete(); m_ov = 1'b0; m_res = '0; m_flg = '0; m_icnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_checks += 6;
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    if (out_result !== 8'h00) begin n_fail++; $display("FAIL reset_result got %h want 00", out_result); end
    if (out_flags !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b want 00000", out_flags); end
    if (invalid_count !== 8'd0) begin n_fail++; $display("FAIL reset_icnt got %0d want 0", invalid_count); end
    if (in_ready !== 1'b1 || alu_control !== 4'd0 || alu_a !== 8'd0) begin
      n_fail++; $display("FAIL reset_head got rdy=%b ctl=%h a=%h want 1 0 00", in_ready, alu_control, alu_a);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, ADD, 8'h0F, 8'h01, 1'b0);
    tick();
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
    n_checks += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", out_valid); end
    if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", fifo_count); end
    if (alu_a !== 8'h0F || alu_b !== 8'h01 || alu_control !== ADD) begin
      n_fail++; $display("FAIL single_head got %h %h %h want 0f 01 0", alu_a, alu_b, alu_control);
    end
    tick();
    n_checks += 2;
    if (out_valid !== 1'b1 || out_result !== 8'h10) begin
      n_fail++; $display("FAIL single_result got v=%b r=%h want 1 10", out_valid, out_result);
    end
    if (out_flags !== 5'b00000) begin n_fail++; $display("FAIL single_flags got %b want 00000", out_flags); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, ADD_C, 8'hFF, 8'h01, 1'b0); tick();
    drive(1'b1, SUB_B, 8'h00, 8'h01, 1'b0); tick();
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 8'h00 || out_flags !== 5'b10100) begin
      n_fail++; $display("FAIL b2b_first got v=%b r=%h f=%b want 1 00 10100", out_valid, out_result, out_flags);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 8'hFF || out_flags !== 5'b01000) begin
      n_fail++; $display("FAIL b2b_second got v=%b r=%h f=%b want 1 ff 01000", out_valid, out_result, out_flags);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ADD, 8'(i * 16), 8'h01, 1'b0); tick();
    end
    drive(1'b1, ADD, 8'hAA, 8'h01, 1'b0); tick(); tick();
    n_checks += 2;
    if (out_valid !== 1'b1 || out_result !== 8'h01) begin
      n_fail++; $display("FAIL bp_hold got v=%b r=%h want 1 01", out_valid, out_result);
    end
    if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full got cnt=%0d rdy=%b want 4 0", fifo_count, in_ready);
    end
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== 8'(k * 16 + 1)) begin
        n_fail++; $display("FAIL bp_order%0d got v=%b r=%h want 1 %h", k, out_valid, out_result, 8'(k * 16 + 1));
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL bp_drain got v=%b cnt=%0d want 0 0", out_valid, fifo_count);
    end
    // Refill, then pop while full with input still offered.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, XOR, 8'(i), 8'h5A, 1'b0); tick();
    end
    out_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin
      n_fail++; $display("FAIL full_stall got rdy=%b cnt=%0d want 0 4", in_ready, fifo_count);
    end
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd3 || in_ready !== 1'b1 || out_result !== 8'h5B) begin
      n_fail++; $display("FAIL full_pop got cnt=%0d rdy=%b r=%h want 3 1 5b", fifo_count, in_ready, out_result);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd0 || out_valid !== 1'b0 || out_result !== 8'h00 ||
        invalid_count !== 8'd0 || alu_control !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset got cnt=%0d v=%b r=%h ic=%0d ctl=%h want 0 0 00 0 0",
               fifo_count, out_valid, out_result, invalid_count, alu_control);
    end
  endtask

  task automatic test_invalid_sat();
    force_inv = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 262; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom));
      tick();
      n_checks++;
      if (invalid_count !== 8'(m_icnt)) begin
        n_fail++; $display("FAIL sat_count%0d got %0d want %0d", i, invalid_count, m_icnt);
      end
      if (out_valid) begin
        n_checks++;
        if (out_flags[FLG_INVALID] !== 1'b1) begin
          n_fail++; $display("FAIL sat_flag%0d got %b want 1", i, out_flags[FLG_INVALID]);
        end
      end
    end
    n_checks++;
    if (invalid_count !== 8'd255) begin n_fail++; $display("FAIL sat_final got %0d want 255", invalid_count); end
    force_inv = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_random();
    logic [3:0] e_ctl;
    logic [7:0] e_a, e_b;
    logic       e_ci;
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      force_inv = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom));
      e_ctl = '0; e_a = '0; e_b = '0; e_ci = 1'b0;
      if (q.size() != 0) begin e_ctl = q[0].ctl; e_a = q[0].a; e_b = q[0].b; e_ci = q[0].ci; end
      n_checks += 4;
      if (fifo_count !== 3'(q.size()) || in_ready !== (q.size() != DEPTH)) begin
        n_fail++; $display("FAIL rnd_count%0d got cnt=%0d rdy=%b want %0d", i, fifo_count, in_ready, q.size());
      end
      if (alu_control !== e_ctl || alu_a !== e_a || alu_b !== e_b || alu_c_in !== e_ci) begin
        n_fail++; $display("FAIL rnd_head%0d got %h %h %h %b want %h %h %h %b", i,
                           alu_control, alu_a, alu_b, alu_c_in, e_ctl, e_a, e_b, e_ci);
      end
      if (out_valid !== m_ov || (m_ov && (out_result !== m_res || out_flags !== m_flg))) begin
        n_fail++; $display("FAIL rnd_out%0d got v=%b r=%h f=%b want %b %h %b", i,
                           out_valid, out_result, out_flags, m_ov, m_res, m_flg);
      end
      if (invalid_count !== 8'(m_icnt)) begin
        n_fail++; $display("FAIL rnd_icnt%0d got %0d want %0d", i, invalid_count, m_icnt);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; force_inv = 1'b0; out_ready = 1'b0;
    m_ov = 1'b0; m_res = '0; m_flg = '0; m_icnt = 0;
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_invalid_sat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
